// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: issue payload, CDB broadcast,
// station entry record and sizing constants.
package module_types;

    localparam int PHYS_W   = 6;
    localparam int ROB_W    = 5;
    localparam int XLEN     = 32;
    localparam int RS_DEPTH = 8;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_t;

    typedef struct packed {
        alu_op_t             alu_op;
        logic [ROB_W-1:0]    robIndex;
        logic [PHYS_W-1:0]   phys_rd;
        logic [XLEN-1:0]     rs1_v;
        logic [XLEN-1:0]     rs2_v;
        logic [XLEN-1:0]     imm;
        logic                use_imm;
    } functional_unit_t;

    typedef struct packed {
        logic                valid;
        logic [PHYS_W-1:0]   commit_phys_rd_addr;
        logic [XLEN-1:0]     data;
    } cdb_output_t;

    typedef struct packed {
        logic                valid;
        functional_unit_t    uop;
        logic [PHYS_W-1:0]   rs1_ps;
        logic [PHYS_W-1:0]   rs2_ps;
        logic                rs1_rdy;
        logic                rs2_rdy;
    } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_picker.sv
// Lowest-index one-hot select; shared by free-slot allocation and ready-entry
// selection.
module rs_priority_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         any
);

    // Two's-complement trick isolates the lowest set request bit.
    assign grant = req & (~req + {{(N-1){1'b0}}, 1'b1});
    assign any   = |req;

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched uops until both operands are
// captured (at dispatch or from the CDB) and issues one ready uop per cycle.
module alu_reservation_station
    import module_types::*;
#(
    parameter int DEPTH   = RS_DEPTH,
    parameter int NUM_CDB = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  functional_unit_t  dispatch_uop,
    input  logic [PHYS_W-1:0] dispatch_rs1_ps,
    input  logic [PHYS_W-1:0] dispatch_rs2_ps,
    input  logic              dispatch_rs1_rdy,
    input  logic              dispatch_rs2_rdy,
    input  cdb_output_t       cdb [NUM_CDB],
    output logic              start,
    output functional_unit_t  functional_arith_unit,
    input  logic              stall
);

    localparam int UOP_W   = $bits(functional_unit_t);
    localparam int ENTRY_W = $bits(rs_entry_t);

    rs_entry_t        entries_r     [DEPTH];
    rs_entry_t        woken_s       [DEPTH];
    rs_entry_t        entries_nxt_s [DEPTH];
    rs_entry_t        new_entry_s;
    logic             wake_s        [DEPTH][NUM_CDB][2];
    logic             byp_s         [NUM_CDB][2];
    logic [DEPTH-1:0] free_s;
    logic [DEPTH-1:0] alloc_oh_s;
    logic [DEPTH-1:0] valid_nxt_s;
    logic [DEPTH-1:0] rdy_nxt_s;
    logic [DEPTH-1:0] sel_nxt_oh_s;
    logic [DEPTH-1:0] sel_oh_r;
    logic             alloc_any_s;
    logic             sel_nxt_any_s;
    logic             dispatch_fire_s;
    logic             issue_fire_s;
    logic [UOP_W-1:0] payload_nxt_s;

    assign dispatch_fire_s = dispatch_valid && dispatch_ready && alloc_any_s;
    assign issue_fire_s    = start && !stall;

    // Tag 0 is the hard-wired zero register and never counts as a producer.
    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        assign free_s[e]      = ~entries_r[e].valid;
        assign valid_nxt_s[e] = entries_nxt_s[e].valid;
        assign rdy_nxt_s[e]   = entries_nxt_s[e].valid && entries_nxt_s[e].rs1_rdy
                                && entries_nxt_s[e].rs2_rdy;
        for (genvar c = 0; c < NUM_CDB; c++) begin : g_cdb
            assign wake_s[e][c][0] = cdb[c].valid
                && (cdb[c].commit_phys_rd_addr != {PHYS_W{1'b0}})
                && (cdb[c].commit_phys_rd_addr == entries_r[e].rs1_ps);
            assign wake_s[e][c][1] = cdb[c].valid
                && (cdb[c].commit_phys_rd_addr != {PHYS_W{1'b0}})
                && (cdb[c].commit_phys_rd_addr == entries_r[e].rs2_ps);
        end
    end

    for (genvar c = 0; c < NUM_CDB; c++) begin : g_bypass
        assign byp_s[c][0] = cdb[c].valid
            && (cdb[c].commit_phys_rd_addr != {PHYS_W{1'b0}})
            && (cdb[c].commit_phys_rd_addr == dispatch_rs1_ps);
        assign byp_s[c][1] = cdb[c].valid
            && (cdb[c].commit_phys_rd_addr != {PHYS_W{1'b0}})
            && (cdb[c].commit_phys_rd_addr == dispatch_rs2_ps);
    end

    rs_priority_picker #(.N(DEPTH)) u_alloc_pick (
        .req   (free_s),
        .grant (alloc_oh_s),
        .any   (alloc_any_s)
    );

    rs_priority_picker #(.N(DEPTH)) u_sel_pick (
        .req   (rdy_nxt_s),
        .grant (sel_nxt_oh_s),
        .any   (sel_nxt_any_s)
    );

    // CDB wakeup of waiting operands; a ready operand is never overwritten.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            woken_s[e] = entries_r[e];
            for (int c = 0; c < NUM_CDB; c++) begin
                woken_s[e].uop.rs1_v = (entries_r[e].valid && !entries_r[e].rs1_rdy && wake_s[e][c][0])
                                       ? cdb[c].data : woken_s[e].uop.rs1_v;
                woken_s[e].rs1_rdy   = woken_s[e].rs1_rdy
                                       | (entries_r[e].valid && wake_s[e][c][0]);
                woken_s[e].uop.rs2_v = (entries_r[e].valid && !entries_r[e].rs2_rdy && wake_s[e][c][1])
                                       ? cdb[c].data : woken_s[e].uop.rs2_v;
                woken_s[e].rs2_rdy   = woken_s[e].rs2_rdy
                                       | (entries_r[e].valid && wake_s[e][c][1]);
            end
        end
    end

    // Build the incoming entry, applying same-cycle CDB bypass and tag-0 forcing.
    always_comb begin
        new_entry_s.valid   = 1'b1;
        new_entry_s.uop     = dispatch_uop;
        new_entry_s.rs1_ps  = dispatch_rs1_ps;
        new_entry_s.rs2_ps  = dispatch_rs2_ps;
        new_entry_s.rs1_rdy = dispatch_rs1_rdy;
        new_entry_s.rs2_rdy = dispatch_rs2_rdy;
        for (int c = 0; c < NUM_CDB; c++) begin
            new_entry_s.uop.rs1_v = (!dispatch_rs1_rdy && byp_s[c][0]) ? cdb[c].data : new_entry_s.uop.rs1_v;
            new_entry_s.rs1_rdy   = new_entry_s.rs1_rdy | byp_s[c][0];
            new_entry_s.uop.rs2_v = (!dispatch_rs2_rdy && byp_s[c][1]) ? cdb[c].data : new_entry_s.uop.rs2_v;
            new_entry_s.rs2_rdy   = new_entry_s.rs2_rdy | byp_s[c][1];
        end
        if (dispatch_rs1_ps == {PHYS_W{1'b0}}) begin
            new_entry_s.rs1_rdy   = 1'b1;
            new_entry_s.uop.rs1_v = {XLEN{1'b0}};
        end else begin
            new_entry_s.rs1_rdy   = new_entry_s.rs1_rdy;
        end
        if (dispatch_rs2_ps == {PHYS_W{1'b0}}) begin
            new_entry_s.rs2_rdy   = 1'b1;
            new_entry_s.uop.rs2_v = {XLEN{1'b0}};
        end else begin
            new_entry_s.rs2_rdy   = new_entry_s.rs2_rdy;
        end
    end

    // Next entry state: flush beats dispatch, which never targets the issuing slot.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            if (flush) begin
                entries_nxt_s[e] = {ENTRY_W{1'b0}};
            end else if (dispatch_fire_s && alloc_oh_s[e]) begin
                entries_nxt_s[e] = new_entry_s;
            end else if (issue_fire_s && sel_oh_r[e]) begin
                entries_nxt_s[e]       = woken_s[e];
                entries_nxt_s[e].valid = 1'b0;
            end else begin
                entries_nxt_s[e] = woken_s[e];
            end
        end
    end

    // Payload of the entry that will be selected next cycle.
    always_comb begin
        payload_nxt_s = {UOP_W{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
            payload_nxt_s = payload_nxt_s | ({UOP_W{sel_nxt_oh_s[e]}} & entries_nxt_s[e].uop);
        end
    end

    // Outputs are registered from next state so they track the current entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                entries_r[e] <= {ENTRY_W{1'b0}};
            end
            sel_oh_r              <= {DEPTH{1'b0}};
            start                 <= 1'b0;
            functional_arith_unit <= {UOP_W{1'b0}};
            dispatch_ready        <= 1'b1;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                entries_r[e] <= entries_nxt_s[e];
            end
            sel_oh_r              <= sel_nxt_oh_s;
            start                 <= sel_nxt_any_s;
            functional_arith_unit <= functional_unit_t'(payload_nxt_s);
            dispatch_ready        <= ~(&valid_nxt_s);
        end
    end

endmodule
